// File: rtl/clear_line_sequencer_if.sv
// Handshake and row-memory bus between the game FSM, the board memory and the
// line-clear sequencer.
interface clear_line_sequencer_if #(
  parameter int unsigned ROWS  = 20,
  parameter int unsigned ROW_W = 30,
  parameter int unsigned AW    = 5,
  parameter int unsigned CNT_W = 5
);
  logic             start;
  logic [ROWS-1:0]  full_flags;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] lines_cleared;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [ROW_W-1:0] rd_data;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [ROW_W-1:0] wr_data;

  modport master (
    input  start, full_flags, rd_data,
    output busy, done, lines_cleared, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, full_flags, rd_data,
    input  busy, done, lines_cleared, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/clear_line_sequencer.sv
// Compacts the board row memory in place after a line clear: surviving rows
// slide down over full rows, vacated top rows are zero-filled.
module clear_line_sequencer #(
  parameter int unsigned ROWS  = 20,
  parameter int unsigned ROW_W = 30,
  parameter int unsigned AW    = 5,
  parameter int unsigned CNT_W = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  clear_line_sequencer_if.master seq
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_WRITE,
    S_FILL,
    S_DONE
  } state_e;

  localparam logic [AW-1:0] BOTTOM = AW'(ROWS - 1);

  state_e           state_q, state_d;
  logic [ROWS-1:0]  mask_q, mask_d;
  logic [AW-1:0]    src_q, src_d;
  logic [AW-1:0]    dst_q, dst_d;
  logic             src_ex_q, src_ex_d;
  logic [CNT_W-1:0] lines_q, lines_d;
  logic [CNT_W-1:0] pop_c;

  logic             rd_en_c;
  logic             wr_en_c;
  logic [ROW_W-1:0] wr_data_c;

  // Saturating decrement: pointers stop at row 0.
  function automatic logic [AW-1:0] dec(input logic [AW-1:0] v);
    return (v == '0) ? v : v - AW'(1);
  endfunction

  always_comb begin
    pop_c = '0;
    for (int unsigned i = 0; i < ROWS; i++) begin
      pop_c = pop_c + CNT_W'(seq.full_flags[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mask_q   <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      src_ex_q <= 1'b0;
      lines_q  <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      src_ex_q <= src_ex_d;
      lines_q  <= lines_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    src_d     = src_q;
    dst_d     = dst_q;
    src_ex_d  = src_ex_q;
    lines_d   = lines_q;
    rd_en_c   = 1'b0;
    wr_en_c   = 1'b0;
    wr_data_c = '0;

    unique case (state_q)
      S_IDLE: begin
        if (seq.start) begin
          mask_d   = seq.full_flags;
          src_d    = BOTTOM;
          dst_d    = BOTTOM;
          src_ex_d = 1'b0;
          lines_d  = pop_c;
          state_d  = (seq.full_flags == '0) ? S_DONE : S_SCAN;
        end
      end

      S_SCAN: begin
        if (src_ex_q) begin
          state_d = S_FILL;
        end else if (mask_q[src_q]) begin
          src_d = dec(src_q);
          if (src_q == '0) begin
            src_ex_d = 1'b1;
            state_d  = S_FILL;
          end
        end else if (src_q == dst_q) begin
          src_d = dec(src_q);
          dst_d = dec(dst_q);
          if (src_q == '0) begin
            state_d = S_DONE;
          end
        end else begin
          rd_en_c = 1'b1;
          state_d = S_WRITE;
        end
      end

      // Read data from the previous SCAN cycle lands on the destination row.
      S_WRITE: begin
        wr_en_c   = 1'b1;
        wr_data_c = seq.rd_data;
        src_d     = dec(src_q);
        dst_d     = dec(dst_q);
        if (src_q == '0) begin
          src_ex_d = 1'b1;
          state_d  = S_FILL;
        end else begin
          state_d = S_SCAN;
        end
      end

      S_FILL: begin
        wr_en_c = 1'b1;
        dst_d   = dec(dst_q);
        if (dst_q == '0) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign seq.busy          = (state_q != S_IDLE);
  assign seq.done          = (state_q == S_DONE);
  assign seq.lines_cleared = lines_q;
  assign seq.rd_en         = rd_en_c;
  assign seq.rd_addr       = rd_en_c ? src_q : '0;
  assign seq.wr_en         = wr_en_c;
  assign seq.wr_addr       = wr_en_c ? dst_q : '0;
  assign seq.wr_data       = wr_data_c;

endmodule

// File: tb/tb_clear_line_sequencer.sv
// Bench for clear_line_sequencer: a row-memory model answers reads, and each
// finished clear is compared with a board compacted directly from the flags.
module tb_clear_line_sequencer;

  localparam int unsigned ROWS  = 20;
  localparam int unsigned ROW_W = 30;
  localparam int unsigned AW    = 5;
  localparam int unsigned CNT_W = 5;

  logic clk;
  logic rst_n;

  clear_line_sequencer_if #(.ROWS(ROWS), .ROW_W(ROW_W), .AW(AW), .CNT_W(CNT_W)) bus ();

  clear_line_sequencer #(.ROWS(ROWS), .ROW_W(ROW_W), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .seq   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;

  logic [ROW_W-1:0] mem     [ROWS];
  logic [ROW_W-1:0] exp_mem [ROWS];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ROW_W-1:0] rand_row();
    logic [31:0] r;
    r = $urandom();
    return r[ROW_W-1:0];
  endfunction

  // Checks every output sits at its reset/idle value.
  task automatic check_idle_outputs(input string tag);
    logic [31:0] agg;
    agg = {28'(0), bus.busy, bus.done, bus.rd_en, bus.wr_en};
    check({tag, "_strobes"}, agg, 32'd0);
    check({tag, "_lines"}, 32'(bus.lines_cleared), 32'd0);
    check({tag, "_addr_data"}, 32'(bus.rd_addr) | 32'(bus.wr_addr) | 32'(bus.wr_data), 32'd0);
  endtask

  task automatic run_case(input string tag, input logic [ROWS-1:0] flags,
                          input bit poke_busy, input bit poke_done);
    int nf, surv, moved, exp_done;
    int cyc, done_cyc, reads, writes, overlap, dirty, bad_rows;
    logic [ROW_W-1:0] pend;
    bit pv;

    for (int r = 0; r < ROWS; r++) mem[r] = rand_row();

    // Reference: survivors stacked from the bottom in original order.
    nf = 0; surv = 0; moved = 0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (flags[r]) nf++;
      else begin
        exp_mem[ROWS-1-surv] = mem[r];
        if (ROWS - 1 - surv != r) moved++;
        surv++;
      end
    end
    for (int i = surv; i < ROWS; i++) exp_mem[ROWS-1-i] = '0;
    exp_done = (nf == 0) ? 1 : 1 + nf + surv + moved + nf;

    @(negedge clk);
    bus.start      = 1'b1;
    bus.full_flags = flags;
    @(posedge clk); #1;
    bus.start      = 1'b0;
    bus.full_flags = ROWS'($urandom());
    bus.rd_data    = '0;

    cyc = 0; done_cyc = 0; reads = 0; writes = 0; overlap = 0; dirty = 0;
    pv = 1'b0; pend = '0;
    while (cyc < 100 && done_cyc == 0) begin
      cyc++;
      @(negedge clk);
      if (cyc == 1) check({tag, "_busy_c1"}, 32'(bus.busy), 32'd1);
      if (bus.rd_en && bus.wr_en) overlap++;
      if (!bus.rd_en && bus.rd_addr != '0) dirty++;
      if (!bus.wr_en && (bus.wr_addr != '0 || bus.wr_data != '0)) dirty++;
      pv = bus.rd_en;
      if (bus.rd_en) begin
        pend = (bus.rd_addr < AW'(ROWS)) ? mem[bus.rd_addr] : '0;
        reads++;
      end
      if (bus.wr_en) begin
        if (bus.wr_addr < AW'(ROWS)) mem[bus.wr_addr] = bus.wr_data;
        writes++;
      end
      if (bus.done) begin
        done_cyc = cyc;
        if (poke_done) begin
          bus.start      = 1'b1;
          bus.full_flags = ROWS'($urandom()) | ROWS'(1);
        end
      end
      if (poke_busy && cyc == 3) begin
        bus.start      = 1'b1;
        bus.full_flags = ROWS'($urandom());
      end
      @(posedge clk); #1;
      bus.rd_data = pv ? pend : '0;
      bus.start   = 1'b0;
    end

    if (done_cyc == 0) check({tag, "_timeout"}, 32'd0, 32'd1);
    check({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
    check({tag, "_lines"}, 32'(bus.lines_cleared), 32'(nf));
    check({tag, "_reads"}, 32'(reads), 32'(moved));
    check({tag, "_writes"}, 32'(writes), 32'(moved + nf));
    check({tag, "_rw_overlap"}, 32'(overlap), 32'd0);
    check({tag, "_idle_bus_zero"}, 32'(dirty), 32'd0);

    bad_rows = 0;
    for (int r = 0; r < ROWS; r++) if (mem[r] !== exp_mem[r]) bad_rows++;
    check({tag, "_board"}, 32'(bad_rows), 32'd0);

    @(negedge clk);
    check({tag, "_post_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_post_done"}, 32'(bus.done), 32'd0);
    check({tag, "_lines_hold"}, 32'(bus.lines_cleared), 32'(nf));
  endtask

  // Bottom-row clear interrupted by reset during a row write.
  task automatic reset_case();
    int cyc;
    for (int r = 0; r < ROWS; r++) mem[r] = rand_row();
    @(negedge clk);
    bus.start      = 1'b1;
    bus.full_flags = ROWS'(1) << (ROWS - 1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 0;
    while (cyc < 11) begin
      cyc++;
      @(negedge clk);
    end
    check("rst_pre_wr_en", 32'(bus.wr_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("rst_hold");
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.full_flags = '0;
    bus.rd_data    = '0;

    #12;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("after_reset");

    run_case("none",      20'h00000, 1'b0, 1'b0);
    run_case("bit19",     20'h80000, 1'b0, 1'b0);
    run_case("bit0",      20'h00001, 1'b0, 1'b0);
    run_case("bits18_19", 20'hC0000, 1'b0, 1'b0);
    run_case("all",       20'hFFFFF, 1'b0, 1'b0);
    run_case("busy_poke", 20'h80000, 1'b1, 1'b0);
    run_case("done_poke", 20'h00421, 1'b0, 1'b1);

    for (int k = 0; k < 10; k++) begin
      logic [31:0] a, b;
      a = $urandom();
      b = $urandom();
      run_case("random", (k % 2 == 0) ? ROWS'(a & b) : ROWS'(a), k % 3 == 1, k % 4 == 2);
    end

    reset_case();
    run_case("post_reset", 20'h40000, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
